// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo1 write port among NREQ valid/ready requesters, bursts of up to BURST words.
// Latency: grant registered one cycle after valid; accept is combinational in GRANT; one IDLE bubble per release.
// Backpressure: wfull stalls the grantee indefinitely; winc and req_ready never assert while wfull=1.
module fifo_wr_arbiter #(
    parameter  int NREQ  = 4,
    parameter  int DSIZE = 8,
    parameter  int BURST = 4,
    localparam int GW    = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CW    = $clog2(BURST + 1)
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic [NREQ-1:0]       req_en,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*DSIZE-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  wfull,
    output logic                  winc,
    output logic [DSIZE-1:0]      wdata,
    output logic                  gnt_valid,
    output logic [GW-1:0]         gnt_id
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]   gnt_id_q, gnt_id_d;
    logic [CW-1:0]   burst_cnt_q, burst_cnt_d;

    logic [NREQ-1:0] elig;
    logic            pick_vld;
    logic [GW-1:0]   pick_id;
    logic [GW-1:0]   scan_id;
    int              scan_idx;
    logic [GW-1:0]   next_ptr;
    logic            granted;
    logic            cur_valid;
    logic            cur_en;
    logic [DSIZE-1:0] cur_data;
    logic            acc;
    logic            burst_done;
    logic            release_gnt;

    assign elig = req_valid & req_en;

    // First eligible requester at or after rr_ptr, wrapping at NREQ.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        scan_idx = 0;
        scan_id  = '0;
        for (int i = 0; i < NREQ; i++) begin
            scan_idx = int'(rr_ptr_q) + i;
            if (scan_idx >= NREQ) begin
                scan_idx = scan_idx - NREQ;
            end
            scan_id = GW'(scan_idx);
            if (!pick_vld && elig[scan_id]) begin
                pick_vld = 1'b1;
                pick_id  = scan_id;
            end
        end
    end

    assign cur_valid   = req_valid[gnt_id_q];
    assign cur_en      = req_en[gnt_id_q];
    assign cur_data    = req_data[gnt_id_q*DSIZE +: DSIZE];

    assign granted     = (state_q == GRANT) && !wrst;
    assign acc         = granted && cur_valid && cur_en && !wfull;
    assign burst_done  = acc && (burst_cnt_q == CW'(BURST - 1));
    assign release_gnt = burst_done || !cur_valid || !cur_en;
    assign next_ptr    = (gnt_id_q == GW'(NREQ - 1)) ? '0 : gnt_id_q + GW'(1);

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_id_d    = gnt_id_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d     = GRANT;
                    gnt_id_d    = pick_id;
                    burst_cnt_d = '0;
                end
            end
            GRANT: begin
                // A stalled grantee (wfull) keeps valid and enable, so it holds here.
                if (release_gnt) begin
                    state_d     = IDLE;
                    rr_ptr_d    = next_ptr;
                    burst_cnt_d = '0;
                end else if (acc) begin
                    burst_cnt_d = burst_cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            gnt_id_q    <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_id_q    <= gnt_id_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign winc      = acc;
    assign req_ready = acc ? (NREQ'(1) << gnt_id_q) : '0;
    assign gnt_valid = granted;
    assign gnt_id    = gnt_id_q;
    assign wdata     = granted ? cur_data : '0;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: behavioural round-robin model compared every cycle, directed scenarios, random soak.
module tb_fifo_wr_arbiter;
    localparam int NREQ      = 4;
    localparam int DSIZE     = 8;
    localparam int BURST     = 4;
    localparam int GW        = 2;
    localparam int SRC_DEPTH = 4096;

    logic                  wclk = 1'b0;
    logic                  wrst;
    logic [NREQ-1:0]       req_en;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  wfull;
    logic                  winc;
    logic [DSIZE-1:0]      wdata;
    logic                  gnt_valid;
    logic [GW-1:0]         gnt_id;

    always #5 wclk = ~wclk;

    fifo_wr_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .BURST(BURST)) dut (
        .wclk(wclk), .wrst(wrst), .req_en(req_en), .req_valid(req_valid),
        .req_data(req_data), .req_ready(req_ready), .wfull(wfull), .winc(winc),
        .wdata(wdata), .gnt_valid(gnt_valid), .gnt_id(gnt_id)
    );

    int checks = 0;
    int failures = 0;

    // requester sources: each keeps its head word until accepted
    logic [7:0] src_mem [NREQ][SRC_DEPTH];
    int         src_rd [NREQ];
    int         src_wr [NREQ];
    bit         rnd_mode = 1'b0;
    bit         rnd_full = 1'b0;
    logic       force_full = 1'b0;

    // behavioural model: current grantee (-1 = none), words in this grant, next priority, last grantee
    int  m_gnt = -1;
    int  m_cnt = 0;
    int  m_ptr = 0;
    int  m_last = 0;
    bit  m_acc;

    logic [7:0]      got_q [$];
    logic [7:0]      exp_q [$];
    int              gstarts [$];
    logic            prev_gv = 1'b0;
    logic            last_winc, last_gv;
    logic [NREQ-1:0] last_ready, ready_s, valid_s;
    logic [GW-1:0]   last_gid;
    logic [7:0]      last_wdata;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push_word(input int i, input logic [7:0] w);
        if (src_wr[i] < SRC_DEPTH) begin
            src_mem[i][src_wr[i]] = w;
            src_wr[i]++;
        end
    endtask

    task automatic load(input int i, input int start, input int n);
        for (int k = 0; k < n; k++) push_word(i, 8'(start + k));
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            bit has;
            has = src_rd[i] < src_wr[i];
            req_valid[i] = has && (!rnd_mode || $urandom_range(0, 3) != 0);
            req_data[i*DSIZE +: DSIZE] = has ? src_mem[i][src_rd[i]] : 8'h00;
        end
        wfull = rnd_full ? ($urandom_range(0, 4) == 0) : force_full;
    endtask

    task automatic cycle();
        logic [NREQ-1:0] exp_ready;
        logic [7:0]      exp_wdata;
        logic            exp_gv;
        logic [1:0]      gi;
        drive();
        @(negedge wclk);
        m_acc = 1'b0; exp_ready = '0; exp_wdata = '0; exp_gv = 1'b0;
        if (!wrst && m_gnt >= 0) begin
            gi        = 2'(m_gnt);
            exp_gv    = 1'b1;
            m_acc     = req_valid[gi] && req_en[gi] && !wfull;
            exp_wdata = req_data[gi*DSIZE +: DSIZE];
            if (m_acc) exp_ready[gi] = 1'b1;
        end
        chk("winc", winc, m_acc);
        chk("req_ready", req_ready, exp_ready);
        chk("wdata", wdata, exp_wdata);
        chk("gnt_valid", gnt_valid, exp_gv);
        if (!wrst) chk("gnt_id", gnt_id, m_last);
        last_winc = winc; last_gv = gnt_valid; last_ready = req_ready;
        last_gid = gnt_id; last_wdata = wdata;
        if (winc) got_q.push_back(wdata);
        if (m_acc) exp_q.push_back(exp_wdata);
        if (gnt_valid && !prev_gv) gstarts.push_back(int'(gnt_id));
        prev_gv = gnt_valid;
        ready_s = req_ready;
        valid_s = req_valid;
        @(posedge wclk);
        if (wrst) begin
            m_gnt = -1; m_ptr = 0; m_cnt = 0; m_last = 0;
        end else if (m_gnt < 0) begin
            for (int k = 0; k < NREQ; k++) begin
                int j;
                j = (m_ptr + k) % NREQ;
                if (req_valid[j] && req_en[j]) begin
                    m_gnt = j; m_last = j; m_cnt = 0;
                    break;
                end
            end
        end else begin
            gi = 2'(m_gnt);
            if (m_acc) m_cnt++;
            if ((m_acc && m_cnt == BURST) || !req_valid[gi] || !req_en[gi]) begin
                m_ptr = (m_gnt + 1) % NREQ;
                m_gnt = -1;
            end
        end
        for (int i = 0; i < NREQ; i++) if (ready_s[i] && valid_s[i]) src_rd[i]++;
        #1;
    endtask

    task automatic do_reset();
        for (int i = 0; i < NREQ; i++) begin src_rd[i] = 0; src_wr[i] = 0; end
        force_full = 1'b0;
        req_en = '1;
        wrst = 1'b1;
        cycle();
        cycle();
        wrst = 1'b0;
        got_q.delete(); exp_q.delete(); gstarts.delete();
    endtask

    function automatic int gstart(input int k);
        return (k < gstarts.size()) ? gstarts[k] : -1;
    endfunction

    initial begin
        logic [12:0] seq13;
        logic [4:0]  seq5;
        int          cnt;
        logic        held;
        int          nm;
        int          exp_order [5];
        wrst = 1'b1; req_en = '1; req_valid = '0; req_data = '0; wfull = 1'b0;
        for (int i = 0; i < NREQ; i++) begin src_rd[i] = 0; src_wr[i] = 0; end

        // reset state
        do_reset();
        cycle();
        chk("rst_gnt_valid", last_gv, 0);
        chk("rst_gnt_id", last_gid, 0);
        chk("rst_winc", last_winc, 0);
        chk("rst_req_ready", last_ready, 0);
        chk("rst_wdata", last_wdata, 0);

        // single requester, 10 words: bursts of 4,4,2 with one-cycle gaps
        do_reset();
        load(0, 1, 10);
        seq13 = '0;
        for (int c = 0; c < 13; c++) begin
            cycle();
            seq13 = {seq13[11:0], last_winc};
        end
        chk("t1_winc_pattern", seq13, 13'b0111101111011);
        chk("t1_count", got_q.size(), 10);
        nm = 0;
        for (int k = 0; k < got_q.size(); k++) if (got_q[k] != 8'(k + 1)) nm++;
        chk("t1_order", nm, 0);

        // all four valid: rotation 0,1,2,3,0
        do_reset();
        for (int i = 0; i < NREQ; i++) load(i, (i + 1) * 16, 8);
        repeat (25) cycle();
        exp_order = '{0, 1, 2, 3, 0};
        for (int k = 0; k < 5; k++) chk("t2_grant_order", gstart(k), exp_order[k]);
        chk("t2_word3", got_q.size() > 4 ? got_q[3] : 8'hFF, 8'h13);
        chk("t2_word4", got_q.size() > 4 ? got_q[4] : 8'hFF, 8'h20);

        // requester 2 stalled by wfull for 5 cycles after 2 words
        do_reset();
        load(2, 8'h30, 6);
        cnt = 0;
        repeat (3) begin cycle(); cnt += int'(last_winc); end
        chk("t3_pre_words", cnt, 2);
        force_full = 1'b1;
        cnt = 0; held = 1'b1;
        repeat (5) begin
            cycle();
            cnt += int'(last_winc) + int'(|last_ready);
            held &= last_gv && (last_gid == 2'd2);
        end
        chk("t3_stall_quiet", cnt, 0);
        chk("t3_stall_held", held, 1);
        force_full = 1'b0;
        cnt = 0;
        repeat (2) begin cycle(); cnt += int'(last_winc); end
        cycle();
        chk("t3_post_words", cnt, 2);
        chk("t3_released", last_gv, 0);

        // requester 1 goes idle after one word while 3 waits
        do_reset();
        load(1, 8'h41, 1);
        load(3, 8'h60, 3);
        seq5 = '0;
        for (int c = 0; c < 5; c++) begin
            cycle();
            seq5 = {seq5[3:0], last_winc};
        end
        chk("t4_winc_pattern", seq5, 5'b01001);
        chk("t4_gnt_id", last_gid, 3);
        repeat (4) cycle();
        chk("t4_count", got_q.size(), 4);
        nm = 0;
        if (got_q.size() == 4) begin
            if (got_q[0] != 8'h41) nm++;
            for (int k = 1; k < 4; k++) if (got_q[k] != 8'(8'h5F + k)) nm++;
        end
        chk("t4_order", nm, 0);

        // only requesters 1 and 3 enabled
        do_reset();
        req_en = 4'b1010;
        for (int i = 0; i < NREQ; i++) load(i, 8'h50 + i * 16, 12);
        repeat (30) cycle();
        chk("t5_g0", gstart(0), 1);
        chk("t5_g1", gstart(1), 3);
        chk("t5_g2", gstart(2), 1);
        chk("t5_g3", gstart(3), 3);

        // reset pulse mid-burst of requester 0 with priority pointer at 2
        do_reset();
        load(1, 8'h70, 1);
        repeat (4) cycle();
        load(0, 8'h80, 8);
        repeat (3) cycle();
        load(2, 8'h90, 4);
        wrst = 1'b1;
        cycle();
        wrst = 1'b0;
        chk("t6_rst_gv", last_gv, 0);
        chk("t6_rst_winc", last_winc, 0);
        chk("t6_rst_ready", last_ready, 0);
        cycle();
        chk("t6_idle_after", last_gv, 0);
        cycle();
        chk("t6_regrant_gv", last_gv, 1);
        chk("t6_regrant_id", last_gid, 0);
        chk("t6_regrant_word", last_wdata, 8'h82);

        // random soak
        do_reset();
        rnd_mode = 1'b1;
        rnd_full = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if (n % 64 == 0) req_en = 4'($urandom_range(1, 15));
            for (int i = 0; i < NREQ; i++) begin
                if (src_rd[i] == src_wr[i] && $urandom_range(0, 7) == 0)
                    for (int k = 0; k < int'($urandom_range(1, 6)); k++) push_word(i, 8'($urandom));
            end
            wrst = ($urandom_range(0, 199) == 0);
            cycle();
            wrst = 1'b0;
        end
        chk("soak_count", got_q.size(), exp_q.size());
        nm = 0;
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) if (got_q[k] != exp_q[k]) nm++;
        chk("soak_data", nm, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
